// File: rtl/datagram_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datagram_transmitter_pkg
// Description : Shared constants, chunk-count helper and transmitter state
//               encoding for the inter-board datagram link.
// Revision    : 1.0 - initial release
// ============================================================================
package datagram_transmitter_pkg;

  // Link data width, fixed to match the childboard receiver.
  localparam int LINK_DATA_W  = 6;
  // Default datagram width produced by the game core.
  localparam int MESSAGE_SIZE = 12;

  // Number of link chunks needed to carry a frame of 'width' bits.
  function automatic int nchunk(input int width);
    return (width + LINK_DATA_W - 1) / LINK_DATA_W;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_ABORT   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous bit.
// Ports       : clk - destination clock
//               rst - asynchronous reset, active-high (clears both flops)
//               d   - asynchronous input
//               q   - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/datagram_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : datagram_transmitter
// Description : Snapshots one MSG_W-bit datagram and serialises it, LSB chunk
//               first, into DATA_W-bit chunks, each carried over a 4-phase
//               req/ack handshake with an asynchronous acknowledge.
// Ports       : clk        - system clock
//               rst        - asynchronous reset, active-high
//               datagram   - frame to send, sampled when a send is accepted
//               send       - single-cycle transmit request
//               ack        - asynchronous acknowledge from the receiver
//               req        - link request (registered)
//               data_trans - link data (registered)
//               busy       - high from accept until return to idle
//               done       - one-cycle pulse after the last ack falls
//               err        - one-cycle pulse when an ack wait times out
// Revision    : 1.0 - initial release
// ============================================================================
module datagram_transmitter
  import datagram_transmitter_pkg::*;
#(
  parameter int MSG_W       = MESSAGE_SIZE,
  parameter int DATA_W      = LINK_DATA_W,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MSG_W-1:0]  datagram,
  input  logic              send,
  input  logic              ack,
  output logic              req,
  output logic [DATA_W-1:0] data_trans,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NCHUNK = nchunk(MSG_W);
  localparam int PAD_W  = NCHUNK * DATA_W;
  localparam int CNT_W  = (NCHUNK > 1)      ? $clog2(NCHUNK)      : 1;
  localparam int SET_W  = (SETUP_CYC > 1)   ? $clog2(SETUP_CYC)   : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit               TO_EN      = (TIMEOUT_CYC != 0);

  tx_state_t         state, state_n;
  logic              ack_s;
  logic              to_hit;
  logic [PAD_W-1:0]  padded;
  logic [PAD_W-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]  chunk_cnt, chunk_n;
  logic [SET_W-1:0]  setup_cnt, setup_n;
  logic [TO_W-1:0]   tcnt, tcnt_n;
  logic              req_n, busy_n, done_n, err_n;
  logic [DATA_W-1:0] data_n;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  // Zero-extend so the unused top bits of the last chunk go out as 0.
  assign padded = PAD_W'(datagram);
  assign to_hit = TO_EN && (tcnt == TO_LAST);

  // shreg holds the chunks still to be sent after the one on data_trans.
  always_comb begin
    state_n = state;
    req_n   = req;
    data_n  = data_trans;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    shreg_n = shreg;
    chunk_n = chunk_cnt;
    setup_n = setup_cnt;
    tcnt_n  = tcnt;

    unique case (state)
      ST_IDLE: begin
        if (send) begin
          data_n  = padded[DATA_W-1:0];
          shreg_n = padded >> DATA_W;
          chunk_n = '0;
          setup_n = '0;
          busy_n  = 1'b1;
          state_n = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          req_n   = 1'b1;
          state_n = ST_WAIT_HI;
        end else begin
          setup_n = setup_cnt + SET_W'(1);
        end
      end

      ST_WAIT_HI: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = ST_WAIT_LO;
        end else if (to_hit) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          state_n = ST_ABORT;
        end else begin
          tcnt_n  = tcnt + TO_W'(1);
        end
      end

      ST_WAIT_LO: begin
        if (!ack_s) begin
          if (chunk_cnt == LAST_CHUNK) begin
            data_n  = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            // req and ack_s are both low here, so the data may change.
            data_n  = shreg[DATA_W-1:0];
            shreg_n = shreg >> DATA_W;
            chunk_n = chunk_cnt + CNT_W'(1);
            setup_n = '0;
            state_n = ST_SETUP;
          end
        end else if (to_hit) begin
          err_n   = 1'b1;
          req_n   = 1'b0;
          state_n = ST_ABORT;
        end else begin
          tcnt_n  = tcnt + TO_W'(1);
        end
      end

      ST_ABORT: begin
        // Let the receiver release ack before accepting another frame.
        if (!ack_s) begin
          busy_n  = 1'b0;
          data_n  = '0;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // The ack timeout restarts on every state entry.
    if (state_n != state) begin
      tcnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req        <= 1'b0;
      data_trans <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      shreg      <= '0;
      chunk_cnt  <= '0;
      setup_cnt  <= '0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      req        <= req_n;
      data_trans <= data_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
      shreg      <= shreg_n;
      chunk_cnt  <= chunk_n;
      setup_cnt  <= setup_n;
      tcnt       <= tcnt_n;
    end
  end

endmodule
`default_nettype wire
